// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Latches the winner's operands, registers the ALU outputs and returns them on a tagged response channel.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   rr_ptr;
  logic   src_q;
  logic   grant0, grant1;
  logic   illegal;

  // Control codes 110/111 are undefined for the ALU.
  assign illegal = (alu_ctrl[2:1] == 2'b11);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | ~rr_ptr);
        grant1 = req1_valid & (~req0_valid |  rr_ptr);
        if (grant0 | grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0 & ~reset;
  assign req1_ready = grant1 & ~reset;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      src_q      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0 | grant1) begin
        alu_a    <= grant1 ? req1_a    : req0_a;
        alu_b    <= grant1 ? req1_b    : req0_b;
        alu_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
        src_q    <= grant1;
        rr_ptr   <= ~grant1;
      end
      if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_src    <= src_q;
        rsp_err    <= illegal;
        rsp_result <= illegal ? '0 : alu_result;
        rsp_zero   <= ~illegal & alu_zero;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (busy flag, round-robin pointer, response age).
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [C-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [C-1:0] alu_ctrl;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_src, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result;

  int   checks = 0;
  int   fails  = 0;
  logic rr_model = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic logic is_illegal(input logic [C-1:0] c);
    return (c == 3'b110) || (c == 3'b111);
  endfunction

  function automatic logic [W-1:0] ref_val(input logic [W-1:0] a, input logic [W-1:0] b, input logic [C-1:0] c);
    case (c)
      3'b000:         return a + b;
      3'b001, 3'b101: return a - b;
      3'b010:         return a & b;
      3'b011:         return a | b;
      3'b100:         return ($signed(a) < $signed(b)) ? W'(1) : '0;
      default:        return '0;
    endcase
  endfunction

  // External ALU stand-in; illegal codes return junk so the arbiter's forcing is visible.
  assign alu_result = is_illegal(alu_ctrl) ? 32'hBAD0_0001 : ref_val(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = is_illegal(alu_ctrl) ? 1'b1 : (ref_val(alu_a, alu_b, alu_ctrl) == '0);

  task automatic drive_req(input int n, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [C-1:0] c);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL reset_hs: got %b required 000", {req1_ready, req0_ready, rsp_valid});
    end
    checks++;
    if ({rsp_src, rsp_result, rsp_zero, rsp_err} !== '0) begin
      fails++; $display("FAIL reset_rsp: got %h required 0", {rsp_src, rsp_result, rsp_zero, rsp_err});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== '0) begin
      fails++; $display("FAIL reset_alu: got %h required 0", {alu_a, alu_b, alu_ctrl});
    end
    reset = 1'b0;
    rr_model = 1'b0;
    @(posedge clk); #1;
  endtask

  // Lone request starting from an idle arbiter; response held for 'hold' cycles before acceptance.
  task automatic do_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [C-1:0] c,
                       input int hold, input string tag);
    logic [W-1:0] er;
    logic         ez, ee;
    ee = is_illegal(c);
    er = ee ? '0 : ref_val(a, b, c);
    ez = !ee && (er == '0);
    rsp_ready = 1'b0;
    drive_req(n, 1'b1, a, b, c);
    #4;
    checks++;
    if ({req1_ready, req0_ready} !== ((n == 1) ? 2'b10 : 2'b01)) begin
      fails++; $display("FAIL %s_grant: got %b required %b", tag, {req1_ready, req0_ready}, (n == 1) ? 2'b10 : 2'b01);
    end
    @(posedge clk); #1;
    drive_req(n, 1'b0, a, b, c);
    rr_model = (n == 0);
    #4;
    checks++;
    if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL %s_exec_hs: got %b required 000", tag, {req1_ready, req0_ready, rsp_valid});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== {a, b, c}) begin
      fails++; $display("FAIL %s_alu_in: got %h required %h", tag, {alu_a, alu_b, alu_ctrl}, {a, b, c});
    end
    @(posedge clk); #1;
    for (int k = 0; k <= hold; k++) begin
      if (k == hold) rsp_ready = 1'b1;
      #4;
      checks++;
      if ({rsp_valid, req1_ready, req0_ready} !== 3'b100) begin
        fails++; $display("FAIL %s_resp_hs: got %b required 100", tag, {rsp_valid, req1_ready, req0_ready});
      end
      checks++;
      if ({rsp_src, rsp_result, rsp_zero, rsp_err} !== {(n == 1), er, ez, ee}) begin
        fails++; $display("FAIL %s_rsp: got %h required %h", tag, {rsp_src, rsp_result, rsp_zero, rsp_err},
                          {(n == 1), er, ez, ee});
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL %s_rsp_clear: got %b required 0", tag, rsp_valid);
    end
  endtask

  task automatic test_single_op();
    do_op(0, 32'd5, 32'd3, 3'b000, 0, "single_add");
  endtask

  task automatic test_contention();
    logic [W-1:0] a[2], b[2], er;
    logic [C-1:0] c[2];
    int w;
    reset = 1'b1;
    a[0] = 32'd7;  b[0] = 32'd2;  c[0] = 3'b001;
    a[1] = 32'hC;  b[1] = 32'hA;  c[1] = 3'b010;
    drive_req(0, 1'b1, a[0], b[0], c[0]);
    drive_req(1, 1'b1, a[1], b[1], c[1]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w  = k % 2;
      er = ref_val(a[w], b[w], c[w]);
      #4;
      checks++;
      if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL cont_grant%0d: got %b required %b", k, {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1;
      a[w] = $urandom(); b[w] = $urandom(); c[w] = C'($urandom_range(0, 5));
      drive_req(w, 1'b1, a[w], b[w], c[w]);
      #4;
      checks++;
      if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
        fails++; $display("FAIL cont_exec%0d: got %b required 000", k, {req1_ready, req0_ready, rsp_valid});
      end
      @(posedge clk); #5;
      checks++;
      if ({rsp_valid, req1_ready, req0_ready, rsp_src, rsp_result} !== {3'b100, (w == 1), er}) begin
        fails++; $display("FAIL cont_rsp%0d: got %h required %h", k, {rsp_valid, req1_ready, req0_ready, rsp_src, rsp_result},
                          {3'b100, (w == 1), er});
      end
      @(posedge clk); #1;
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    rsp_ready = 1'b0;
    rr_model = 1'b0;
  endtask

  task automatic test_backpressure();
    do_op(1, 32'd4, 32'd4, 3'b101, 5, "bp_beq");
    do_op(0, 32'd9, 32'd4, 3'b001, 0, "bp_next");
  endtask

  task automatic test_illegal();
    do_op(0, 32'd1, 32'd1, 3'b111, 0, "illegal");
    do_op(1, 32'd6, 32'd6, 3'b001, 0, "after_illegal");
  endtask

  task automatic test_slt_or();
    do_op(1, 32'd1, 32'd2, 3'b100, 0, "slt");
    do_op(1, 32'd2, 32'd1, 3'b011, 0, "or");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b100, 0, "slt_neg");
  endtask

  task automatic test_reset_mid_op();
    drive_req(0, 1'b1, 32'd9, 32'd9, 3'b000);
    #4;
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, '0, '0);
    rsp_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #4;
    checks++;
    if ({rsp_valid, req1_ready, req0_ready, alu_a, alu_b, alu_ctrl} !== '0) begin
      fails++; $display("FAIL midrst_out: got %h required 0", {rsp_valid, req1_ready, req0_ready, alu_a, alu_b, alu_ctrl});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL midrst_noresp%0d: got %b required 0", k, rsp_valid);
      end
      @(posedge clk); #1;
    end
    drive_req(0, 1'b1, 32'd1, 32'd1, 3'b000);
    drive_req(1, 1'b1, 32'd1, 32'd1, 3'b000);
    #4;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++; $display("FAIL midrst_rrptr: got %b required 01", {req1_ready, req0_ready});
    end
    #1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    rsp_ready = 1'b0;
    rr_model = 1'b0;
    @(posedge clk); #1;
  endtask

  // Model: arbiter is busy from a grant edge until the response handshake edge;
  // the response is visible from the second cycle after the grant.
  task automatic test_random(input int ncycles);
    logic         v[2];
    logic [W-1:0] qa[2], qb[2];
    logic [C-1:0] qc[2];
    logic         busy, have_last, drain, ee, ez;
    int           age, win, cur_n;
    logic [W-1:0] cur_a, cur_b, er;
    logic [C-1:0] cur_c;
    v[0] = 1'b0; v[1] = 1'b0;
    busy = 1'b0; have_last = 1'b0; age = 0; cur_n = 0;
    cur_a = '0; cur_b = '0; cur_c = '0;
    for (int cyc = 0; cyc < ncycles + 20; cyc++) begin
      drain = (cyc >= ncycles);
      for (int n = 0; n < 2; n++) begin
        if (drain) v[n] = 1'b0;
        else if (!v[n] && $urandom_range(0, 1) == 1) begin
          v[n]  = 1'b1;
          qa[n] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom());
          qb[n] = ($urandom_range(0, 3) == 0) ? qa[n] : W'($urandom());
          qc[n] = C'($urandom_range(0, 7));
        end
        drive_req(n, v[n], qa[n], qb[n], qc[n]);
      end
      rsp_ready = drain || ($urandom_range(0, 9) < 6);
      #4;
      win = -1;
      if (!busy) begin
        if (v[0] && v[1]) win = rr_model ? 1 : 0;
        else if (v[0])    win = 0;
        else if (v[1])    win = 1;
      end
      checks++;
      if ({req1_ready, req0_ready} !== {(win == 1), (win == 0)}) begin
        fails++; $display("FAIL rnd_ready c%0d: got %b required %b", cyc, {req1_ready, req0_ready}, {(win == 1), (win == 0)});
      end
      checks++;
      if (rsp_valid !== (busy && age >= 1)) begin
        fails++; $display("FAIL rnd_valid c%0d: got %b required %b", cyc, rsp_valid, (busy && age >= 1));
      end
      if (busy && age >= 1) begin
        ee = is_illegal(cur_c);
        er = ee ? '0 : ref_val(cur_a, cur_b, cur_c);
        ez = !ee && (er == '0);
        checks++;
        if ({rsp_src, rsp_result, rsp_zero, rsp_err} !== {(cur_n == 1), er, ez, ee}) begin
          fails++; $display("FAIL rnd_rsp c%0d: got %h required %h", cyc, {rsp_src, rsp_result, rsp_zero, rsp_err},
                            {(cur_n == 1), er, ez, ee});
        end
      end
      if (have_last) begin
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== {cur_a, cur_b, cur_c}) begin
          fails++; $display("FAIL rnd_alu c%0d: got %h required %h", cyc, {alu_a, alu_b, alu_ctrl}, {cur_a, cur_b, cur_c});
        end
      end
      @(posedge clk); #1;
      if (win >= 0) begin
        busy = 1'b1; age = 0; cur_n = win; have_last = 1'b1;
        cur_a = qa[win]; cur_b = qb[win]; cur_c = qc[win];
        rr_model = (win == 0);
        v[win] = 1'b0;
      end else if (busy) begin
        if (age >= 1 && rsp_ready) busy = 1'b0;
        else if (age < 2) age++;
      end
    end
    #4;
    checks++;
    if (rsp_valid !== 1'b0 || busy) begin
      fails++; $display("FAIL rnd_drain: got rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_slt_or();
    test_reset_mid_op();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
